// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-stage to multiply/divide sequencer bus
//
// Ports carried:
//   StartE     EX holds a valid MDU instruction
//   MDUOpE     3-bit op code (none/MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   SrcAE      rs operand
//   SrcBE      rt operand
//   FlushMDU   abort in-flight work (exception taken)
//   MDUReadyE  0 = EX must stall
//   HI, LO     committed HI/LO registers
//   DivZero    sticky divide-by-zero flag
// master = EX stage side, slave = mdu_ctrl.

interface mdu_ctrl_if;
   logic        StartE;
   logic [2:0]  MDUOpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        FlushMDU;
   logic        MDUReadyE;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        DivZero;

   modport master (
      output StartE, MDUOpE, SrcAE, SrcBE, FlushMDU,
      input  MDUReadyE, HI, LO, DivZero
   );

   modport slave (
      input  StartE, MDUOpE, SrcAE, SrcBE, FlushMDU,
      output MDUReadyE, HI, LO, DivZero
   );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide sequencer owning HI/LO
//
// Runs MULT/MULTU as 32-step shift-add and DIV/DIVU as 32-step restoring
// divide on magnitudes, then sign-fixes and commits HI/LO. MTHI/MTLO write
// directly with no stall.
//
// Ports:
//   clk   pipeline clock
//   rst   asynchronous active-high reset
//   bus   mdu_ctrl_if.slave (StartE, MDUOpE, SrcAE, SrcBE, FlushMDU in;
//         MDUReadyE, HI, LO, DivZero out)
//
// Optional build macro: MDU_FAST_MULT_EN - single-cycle 33x33 signed
// multiply for MULT/MULTU; divide remains iterative.

module mdu_ctrl (
   input logic       clk,
   input logic       rst,
   mdu_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state, state_nx;
   logic [5:0]  cnt;
   logic [63:0] work;      // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0] opb;       // mult: multiplicand; div: divisor
   logic [31:0] a_mag;     // dividend magnitude, kept for divide-by-zero HI
   logic        is_div_r;
   logic        neg_a;
   logic        neg_b;
   logic        b_zero;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic        dz_r;

   // op decode
   logic op_mul, op_div, op_sgn, op_mthi, op_mtlo;
   logic start_it, fast_go, last_step;
   logic [31:0] a_abs, b_abs;

   assign op_mul  = (bus.MDUOpE == 3'b001) || (bus.MDUOpE == 3'b010);
   assign op_div  = (bus.MDUOpE == 3'b011) || (bus.MDUOpE == 3'b100);
   assign op_sgn  = (bus.MDUOpE == 3'b001) || (bus.MDUOpE == 3'b011);
   assign op_mthi = (bus.MDUOpE == 3'b101);
   assign op_mtlo = (bus.MDUOpE == 3'b110);

   assign start_it = (state == S_IDLE) && bus.StartE && !bus.FlushMDU && (op_mul || op_div);
   assign last_step = (state == S_BUSY) && (cnt == 6'd31) && !bus.FlushMDU;

   assign a_abs = (op_sgn && bus.SrcAE[31]) ? -bus.SrcAE : bus.SrcAE;
   assign b_abs = (op_sgn && bus.SrcBE[31]) ? -bus.SrcBE : bus.SrcBE;

`ifdef MDU_FAST_MULT_EN
   logic signed [32:0] fast_a, fast_b;
   logic [63:0]        fast_prod;
   assign fast_a    = $signed({op_sgn & bus.SrcAE[31], bus.SrcAE});
   assign fast_b    = $signed({op_sgn & bus.SrcBE[31], bus.SrcBE});
   assign fast_prod = 64'(fast_a) * 64'(fast_b);
   assign fast_go   = start_it && op_mul;
`else
   logic [63:0] fast_prod;
   assign fast_prod = 64'd0;
   assign fast_go   = 1'b0;
`endif

   // one multiply step: add multiplicand when multiplier LSB set, shift right
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opb} : 33'd0);
   assign mul_step = {mul_sum, work[31:1]};

   // one restoring-divide step: shifted remainder can reach 33 bits
   logic [32:0] rem_sh;
   logic [33:0] div_diff;
   logic        div_ge;
   logic [63:0] div_step;
   assign rem_sh   = work[63:31];
   assign div_diff = {1'b0, rem_sh} - {2'b00, opb};
   assign div_ge   = !div_diff[33];
   assign div_step = div_ge ? {div_diff[31:0], work[30:0], 1'b1}
                            : {rem_sh[31:0],   work[30:0], 1'b0};

   logic [63:0] work_step;
   assign work_step = is_div_r ? div_step : mul_step;

   // sign fix applied to the value produced by the final step
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix, dvd_back;
   assign prod_fix = (neg_a ^ neg_b) ? -work_step : work_step;
   assign quo_fix  = (neg_a ^ neg_b) ? -work_step[31:0] : work_step[31:0];
   assign rem_fix  = neg_a ? -work_step[63:32] : work_step[63:32];
   assign dvd_back = neg_a ? -a_mag : a_mag;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      if (bus.FlushMDU) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start_it) state_nx = fast_go ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt == 6'd31) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // outputs: issue cycle already stalls; flush releases EX immediately
   always_comb begin
      bus.MDUReadyE = 1'b1;
      if (start_it || ((state == S_BUSY) && !bus.FlushMDU)) bus.MDUReadyE = 1'b0;
   end

   assign bus.HI      = hi_r;
   assign bus.LO      = lo_r;
   assign bus.DivZero = dz_r;

   // datapath and HI/LO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work     <= 64'd0;
         opb      <= 32'd0;
         a_mag    <= 32'd0;
         cnt      <= 6'd0;
         is_div_r <= 1'b0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         b_zero   <= 1'b0;
         hi_r     <= 32'd0;
         lo_r     <= 32'd0;
         dz_r     <= 1'b0;
      end else begin
         if (fast_go) begin
            {hi_r, lo_r} <= fast_prod;
         end else if (start_it) begin
            work     <= op_div ? {32'd0, a_abs} : {32'd0, b_abs};
            opb      <= op_div ? b_abs : a_abs;
            a_mag    <= a_abs;
            neg_a    <= op_sgn & bus.SrcAE[31];
            neg_b    <= op_sgn & bus.SrcBE[31];
            is_div_r <= op_div;
            b_zero   <= (bus.SrcBE == 32'd0);
            cnt      <= 6'd0;
         end

         if ((state == S_IDLE) && bus.StartE && !bus.FlushMDU) begin
            if (op_mthi) hi_r <= bus.SrcAE;
            if (op_mtlo) lo_r <= bus.SrcAE;
         end

         if ((state == S_BUSY) && !bus.FlushMDU) begin
            work <= work_step;
            cnt  <= cnt + 6'd1;
         end

         if (last_step) begin
            if (is_div_r) begin
               if (b_zero) begin
                  lo_r <= 32'hFFFF_FFFF;
                  hi_r <= dvd_back;
                  dz_r <= 1'b1;
               end else begin
                  lo_r <= quo_fix;
                  hi_r <= rem_fix;
                  dz_r <= 1'b0;
               end
            end else begin
               {hi_r, lo_r} <= prod_fix;
            end
         end
      end
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the iterative multiply/divide unit in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs the 32-step shift-add / restoring-divide engine. It owns the HI/LO registers and drives `MDUReadyE`, which the hazard unit uses to stall IF/ID/EX. `FlushMDU` (tied to `GoHandlerM`) aborts in-flight work when an exception is taken.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset; asynchronous, active-high
- `StartE`  in  1  EX holds a valid MDU instruction
- `MDUOpE`  in  3  op code:
  - 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
  - 111 reserved, treated as none
- `SrcAE`  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
- `SrcBE`  in  32  rt operand (multiplier / divisor)
- `FlushMDU`  in  1  abort; connected to `GoHandlerM`
- `MDUReadyE`  out  1  0 = EX must stall
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `DivZero`  out  1  sticky flag: last completed DIV/DIVU had divisor 0; cleared by the next completed DIV/DIVU

## Operation
- States: IDLE, BUSY, DONE; 6-bit step counter; 64-bit working register; latched operand signs.
- IDLE:
  - MULT*/DIV* with `StartE`=1 and `FlushMDU`=0: latch absolute values (signed ops) or raw operands (unsigned ops), counter=0, go to BUSY.
  - MTHI/MTLO: write HI/LO at the clock edge and stay in IDLE.
- BUSY: one multiply or divide step per cycle. After step 31, sign-fix the result, write HI/LO, go to DONE.
- DONE: one cycle; `StartE` is ignored; go to IDLE.
- Multiply: {HI,LO} = 64-bit product. Signed product is negated if operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - Signed quotient is negated if signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero: LO=0xFFFFFFFF, HI=SrcAE, `DivZero`=1.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- `FlushMDU`=1 in any state:
  - next state is IDLE
  - HI/LO and `DivZero` unchanged
  - no new op starts, MTHI/MTLO suppressed
- Reset: state IDLE, HI=0, LO=0, `DivZero`=0, `MDUReadyE`=1.

## Timing
- `MDUReadyE` is combinational: 0 when (IDLE and `StartE` and op is MULT*/DIV* and not `FlushMDU`) or (BUSY and not `FlushMDU`); otherwise 1.
- The issue cycle T already stalls, so EX holds the instruction.
- Iterative MULT/DIV:
  - `MDUReadyE`=0 for cycles T..T+32 (33 cycles).
  - HI/LO update at the end of T+32.
  - DONE at T+33 with `MDUReadyE`=1; the instruction leaves EX.
- MTHI/MTLO: zero stall. New value is visible the cycle after the edge.
- A following MDU instruction in EX at T+34 starts from IDLE.
- HI/LO reads (MFHI/MFLO) in a cycle with `MDUReadyE`=1 see the committed value. While BUSY, EX is stalled, so no read can observe a partial result.
- Flush while BUSY: `MDUReadyE`=1 in the same cycle, so EX is not held against the handler redirect.
- Reset asserted mid-op: immediate IDLE; the partial result is discarded.

## Configuration
- `MDU_FAST_MULT_EN`
  - Defined: MULT/MULTU use a single-cycle 33x33 signed `*`. Issue cycle T has `MDUReadyE`=0, HI/LO are written at the end of T, T+1 is DONE. Divide stays iterative.
  - Undefined: all multiplies use the 32-step iterative path described above.

## Test plan
- After reset: HI=LO=0, `DivZero`=0, `MDUReadyE`=1.
- MULT 0xFFFFFFFE x 0x00000003 -> ready low 33 cycles (1 with fast-mult), then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Divide cases:
  - DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 -> LO=14, HI=2.
  - DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, `DivZero`=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> no stall; HI/LO hold those values. A following MULT 0x1 x 0x1 overwrites them to HI=0, LO=1.
- DIV started; `FlushMDU` pulsed at busy cycle 10 -> `MDUReadyE`=1 that cycle, state IDLE, HI/LO keep prior values. A new DIVU 9/3 afterwards gives LO=3, HI=0.
- `rst` asserted during BUSY of MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=LO=0 immediately, `MDUReadyE`=1. After release, the same op yields HI=0xFFFFFFFE, LO=0x00000001.
